rr_bus_scheduler: RTL and testbench
===================================

Name: rr_bus_scheduler

Overview:
- Round-robin scheduler that shares one single-transaction bus resource between N requesters.
- Unlike a per-cycle arbiter, it holds a grant for the whole transaction until the resource signals completion, the requester aborts, or a watchdog expires.
- The RR pointer advances only when a granted transaction finishes.
- Sits between the requester ports and the shared bus mux; grant drives the mux select and grant_id tags the transaction.

Parameters:
- N, 4, number of requesters (2..16).
- TIMEOUT, 16, maximum cycles a grant may be held before forced release (2..255).

Ports:
- clk  input  1  rising-edge clock.
- resetN  input  1  asynchronous active-low reset.
- req  input  N  per-requester request level; must stay high until released.
- done  input  1  one-cycle completion pulse from the shared resource for the current transaction.
- grant  output  N  one-hot registered grant; all-zero when idle.
- grant_id  output  $clog2(N)  binary index of the granted requester; 0 when idle.
- busy  output  1  high while any grant is held.
- timeout_err  output  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset (async, resetN low):
  - grant=0, grant_id=0, busy=0, timeout_err=0.
  - state=IDLE, hold counter=0, pointer=N-1, so requester 0 has first priority after reset.
- Winner function, combinational: given pointer P and vector R, pick the lowest set index strictly above P. If there is none, pick the lowest set index in R, which wraps around and may equal P. If R=0, there is no winner.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - done is ignored.
  - If req!=0: on the next edge, grant=onehot(winner(pointer, req)), grant_id=winner, busy=1, counter=0, state=HOLD. Latency from req to grant is 1 cycle.
  - Else stay in IDLE.
- HOLD:
  - grant and grant_id are stable.
  - The counter increments each cycle, saturating; width $clog2(TIMEOUT+1).
- HOLD release conditions, checked in priority order each cycle:
  1. done=1: normal completion.
  2. req[grant_id]=0: abort, no error.
  3. counter==TIMEOUT-1: watchdog; timeout_err=1 for the following cycle only.
- On any release:
  - pointer <= grant_id.
  - If req with the releasing bit masked off is non-zero, re-grant on the same edge to winner(grant_id, that masked vector). This is a back-to-back transfer with 0 dead cycles; counter resets to 0; state stays HOLD.
  - Otherwise, if only the releasing requester still has req high (done case), re-grant it. Counter resets; it is a new transaction.
  - Otherwise go to IDLE with grant=0, busy=0, grant_id=0.
- Simultaneous events:
  - done and timeout in the same cycle: done wins, no timeout_err.
  - done and abort in the same cycle: treated as done.
- Invariants: grant is always one-hot or zero, and changes only at release or on an IDLE→HOLD transition. New requests arriving during HOLD never preempt the current grant.
- Reset asserted mid-HOLD: outputs clear immediately (asynchronously); no timeout_err is produced.
- Pointer is not updated on the IDLE→HOLD transition, only on release.

Test Plan:
- Reset release with req=4'b1010, done pulsed after 3 cycles in HOLD -> grant=4'b0010 one cycle after req. It holds 3 cycles, then on done switches to grant=4'b1000, grant_id=3, with no idle cycle.
- All req=4'b1111 held, done every 2nd cycle of HOLD -> grant sequence 0001,0010,0100,1000,0001. Each requester gets exactly one transaction per rotation.
- req=4'b0100 only, done never asserted, TIMEOUT=16 -> grant=4'b0100 for 16 cycles. Then timeout_err pulses high for exactly 1 cycle, and because req[2] is still high, grant=4'b0100 again with counter restarted.
- While granted to index 1, req[1] drops and req=4'b1001 remains -> next edge grant=4'b1000 (winner above pointer 1), timeout_err stays 0.
- done and counter==TIMEOUT-1 in the same cycle -> release with timeout_err=0. Separately, done pulsed while in IDLE -> no state change, grant stays 0.
- resetN driven low mid-HOLD with grant=4'b0100 -> grant=0, busy=0 immediately, without waiting for a clock edge. After release with req=4'b0101, grant=4'b0001 (pointer back to N-1).

Source files
------------

// File: rtl/rr_bus_scheduler.sv
// Round-robin scheduler for one shared single-transaction bus: a grant is held
// until done, requester abort, or watchdog expiry, then passed on with no dead cycle.
module rr_bus_scheduler #(
    parameter  int N       = 4,
    parameter  int TIMEOUT = 16,
    localparam int IW      = (N > 1) ? $clog2(N) : 1,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic          busy,
    output logic          timeout_err,
    output logic          state_dbg
);

    // Handshake: req[i] is a level held until the grant for i is released;
    // done is a single-cycle pulse only meaningful while a grant is held.

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] gid_q, gid_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          terr_q, terr_d;

    logic [IW-1:0] base;
    logic          win_v;
    logic [IW-1:0] win_i;
    logic          rel_done, rel_abort, rel_wdog, release_now;

    // Lowest set index strictly above p, else lowest set index overall.
    function automatic logic [IW:0] pick(input logic [IW-1:0] p, input logic [N-1:0] r);
        logic          hi_v, lo_v;
        logic [IW-1:0] hi_i, lo_i;
        hi_v = 1'b0;
        lo_v = 1'b0;
        hi_i = '0;
        lo_i = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) begin
                lo_v = 1'b1;
                lo_i = IW'(i);
                if (IW'(i) > p) begin
                    hi_v = 1'b1;
                    hi_i = IW'(i);
                end
            end
        end
        return hi_v ? {1'b1, hi_i} : {lo_v, lo_i};
    endfunction

    // Searching from grant_id over the full req vector gives the same answer as
    // searching the masked vector, and falls back to the releasing requester itself.
    assign base            = (state_q == HOLD) ? gid_q : ptr_q;
    assign {win_v, win_i}  = pick(base, req);

    assign rel_done    = done;
    assign rel_abort   = ~req[gid_q];
    assign rel_wdog    = (cnt_q == CW'(TIMEOUT - 1));
    assign release_now = rel_done | rel_abort | rel_wdog;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_v) begin
                    state_d = HOLD;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << win_i;
                    gid_d   = win_i;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (release_now) begin
                    ptr_d  = gid_q;
                    terr_d = ~rel_done & ~rel_abort & rel_wdog;
                    cnt_d  = '0;
                    if (win_v) begin
                        grant_d = {{(N-1){1'b0}}, 1'b1} << win_i;
                        gid_d   = win_i;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        gid_d   = '0;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= IW'(N - 1);
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = gid_q;
    assign busy        = (state_q == HOLD);
    assign timeout_err = terr_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_rr_bus_scheduler.sv
// Bench for rr_bus_scheduler (N=4, TIMEOUT=16): vector table plus hand-written
// timeout, simultaneous-event and asynchronous-reset sequences.
module tb_rr_bus_scheduler;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;
    localparam int W       = 9;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_err;
    logic       state_dbg;

    rr_bus_scheduler #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
        logic       terr;
    } vec_t;

    vec_t           vecs[$];
    logic [W-1:0]   exp_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;

    function automatic logic [W-1:0] pack(input logic [3:0] g, input logic [1:0] id,
                                          input logic b, input logic t);
        return {g, id, b, t, b};
    endfunction

    function automatic void add(input logic [3:0] r, input logic d, input logic [3:0] g,
                                input logic [1:0] id, input logic b, input logic t);
        vec_t v;
        v.req = r; v.done = d; v.grant = g; v.id = id; v.busy = b; v.terr = t;
        vecs.push_back(v);
    endfunction

    // scoreboard
    task automatic check(input string name);
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        act_v = {grant, grant_id, busy, timeout_err, state_dbg};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected entry, got %b", name, act_v);
        end else begin
            exp_v = exp_q.pop_front();
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got {grant,id,busy,terr,state}=%b expected %b", name, act_v, exp_v);
            end
        end
    endtask

    // driver: apply inputs away from the edge, sample 1 time unit after it
    task automatic step(input logic [3:0] r, input logic d, input logic [3:0] g,
                        input logic [1:0] id, input logic b, input logic t, input string name);
        exp_q.push_back(pack(g, id, b, t));
        req  = r;
        done = d;
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        // back-to-back handoff on done: 1010 -> grant 1 then 3
        add(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        // full rotation, done every second HOLD cycle
        add(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        // abort of index 1 with 1001 pending -> 3 wins (above pointer 1)
        add(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        // done while idle is ignored
        add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

        #12;
        exp_q.push_back(pack(4'b0000, 2'd0, 1'b0, 1'b0));
        check("reset_state");
        resetN = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].done, vecs[i].grant, vecs[i].id,
                 vecs[i].busy, vecs[i].terr, $sformatf("vec%0d", i));
        end

        // watchdog: 16 held cycles, 1-cycle timeout_err, same requester regranted
        for (int k = 0; k < TIMEOUT; k++)
            step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, $sformatf("wdog_hold%0d", k));
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "wdog_pulse");
        for (int k = 1; k < TIMEOUT; k++)
            step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, $sformatf("wdog_rehold%0d", k));
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "wdog_pulse2");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "wdog_idle");

        // done on the watchdog cycle: done wins, no timeout_err
        for (int k = 0; k < TIMEOUT; k++)
            step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, $sformatf("race_hold%0d", k));
        step(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "race_done");
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "race_after");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "race_idle");

        // move the pointer to 0, then reset mid-HOLD
        step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "ptr0_grant");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "ptr0_idle");
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "rst_pre");
        #2 resetN = 1'b0;
        #1;
        exp_q.push_back(pack(4'b0000, 2'd0, 1'b0, 1'b0));
        check("rst_async_clear");
        req = 4'b0101;
        #2 resetN = 1'b1;
        step(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "rst_ptr_restart");
        step(4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "rst_next");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "final_idle");

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
